muldiv_ctrl: RTL and testbench

//  Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers.
//  It executes MULT/MULTU with a shift-add engine and DIV/DIVU with a restoring divider, one bit per cycle.
//  It sits beside the ALU in the execute stage: decode issues ops, and busy stalls MFHI/MFLO and further HI/LO ops.

---
 rtl/muldiv_ctrl.sv | 171 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO registers.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle MULT/MULTU through FIX).
module muldiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // state | meaning
   // IDLE  | waiting for an op; MTHI/MTLO complete here
   // PREP  | magnitudes of operands, accumulator loaded
   // CALC  | one shift-add or restoring-divide step per cycle, WIDTH cycles
   // FIX   | sign correction and HI/LO commit
   typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

   localparam int CW = $clog2(WIDTH + 1);

   state_t             state, state_nx;
   logic [2:0]         op_q, op_nx;
   logic [WIDTH-1:0]   a_q, a_nx, b_q, b_nx;
   logic [WIDTH-1:0]   mag_q, mag_nx;
   logic [2*WIDTH-1:0] acc, acc_nx;
   logic [CW-1:0]      cnt, cnt_nx;
   logic [WIDTH-1:0]   hi_nx, lo_nx;
   logic               done_nx;

   logic               is_div, is_sgn, div_zero, neg_res, neg_rem;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     mul_sum, rem_sh, diff;
   logic [2*WIDTH:0]   mul_wide;
   logic [2*WIDTH-1:0] mul_step, div_step, prod;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign is_div   = op_q[1];
   assign is_sgn   = ~op_q[0];
   assign div_zero = is_div && (b_q == '0);
   assign neg_res  = is_sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
   assign neg_rem  = is_sgn && a_q[WIDTH-1];
   assign a_abs    = (is_sgn && a_q[WIDTH-1]) ? -a_q : a_q;
   assign b_abs    = (is_sgn && b_q[WIDTH-1]) ? -b_q : b_q;

   // Shift-add: acc = {partial product, remaining multiplier bits}
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_q};
   assign mul_wide = acc[0] ? {mul_sum, acc[WIDTH-1:0]} : {1'b0, acc};
   assign mul_step = mul_wide[2*WIDTH:1];

   // Restoring divide: acc = {remainder, quotient}; rem_sh carries the bit shifted out
   assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
   assign diff     = rem_sh - {1'b0, mag_q};
   assign div_step = diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                 : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

`ifdef MULDIV_FAST_MUL_EN
   assign prod = is_sgn ? ({{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q})
                        : ({{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q});
`else
   assign prod = neg_res ? -acc : acc;
`endif

   assign quo_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_fix = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   always_comb begin
      state_nx = state;
      op_nx    = op_q;
      a_nx     = a_q;
      b_nx     = b_q;
      mag_nx   = mag_q;
      acc_nx   = acc;
      cnt_nx   = cnt;
      hi_nx    = hi;
      lo_nx    = lo;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               if (op <= 3'd3) begin
                  op_nx = op;
                  a_nx  = op1;
                  b_nx  = op2;
`ifdef MULDIV_FAST_MUL_EN
                  state_nx = op[1] ? PREP : FIX;
`else
                  state_nx = PREP;
`endif
               end else if (op == 3'd4) begin
                  hi_nx   = op1;
                  done_nx = 1'b1;
               end else if (op == 3'd5) begin
                  lo_nx   = op1;
                  done_nx = 1'b1;
               end
            end
         end
         PREP: begin
            mag_nx   = is_div ? b_abs : a_abs;
            acc_nx   = {{WIDTH{1'b0}}, (is_div ? a_abs : b_abs)};
            cnt_nx   = '0;
            state_nx = CALC;
         end
         CALC: begin
            // Divide-by-zero leaves the working registers alone but keeps the normal latency
            if (!div_zero)
               acc_nx = is_div ? div_step : mul_step;
            cnt_nx = cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1))
               state_nx = FIX;
         end
         FIX: begin
            if (!is_div) begin
               hi_nx = prod[2*WIDTH-1:WIDTH];
               lo_nx = prod[WIDTH-1:0];
            end else if (div_zero) begin
               hi_nx = a_q;
               lo_nx = '1;
            end else begin
               hi_nx = rem_fix;
               lo_nx = quo_fix;
            end
            done_nx  = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (abort && state != IDLE) begin
         state_nx = IDLE;
         hi_nx    = hi;
         lo_nx    = lo;
         done_nx  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         mag_q <= '0;
         acc   <= '0;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         op_q  <= op_nx;
         a_q   <= a_nx;
         b_q   <= b_nx;
         mag_q <= mag_nx;
         acc   <= acc_nx;
         cnt   <= cnt_nx;
         hi    <= hi_nx;
         lo    <= lo_nx;
         done  <= done_nx;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus random mul/div against an arithmetic model.
module tb_muldiv_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd6;
   logic [31:0] op1 = '0, op2 = '0;
   logic        abort = 1'b0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int checks = 0;
   int failures = 0;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 34;
`endif
   localparam int DIV_LAT = 34;

   muldiv_ctrl #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op1(op1), .op2(op2),
      .abort(abort), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // Reference: plain 64-bit arithmetic from the op definitions
   function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] res;
      sa = o[0] ? longint'({32'b0, a}) : longint'($signed(a));
      sb = o[0] ? longint'({32'b0, b}) : longint'($signed(b));
      if (!o[1]) begin
         res = 64'(sa * sb);
      end else if (b == 32'd0) begin
         res = {a, 32'hFFFF_FFFF};
      end else begin
         q = sa / sb;
         r = sa % sb;
         res = {r[31:0], q[31:0]};
      end
      return res;
   endfunction

   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
      @(negedge clk);
      start = 1'b1; op = o; op1 = a; op2 = b;
      @(posedge clk); #1;
      start = 1'b0; op = 3'd6;
      bcnt = busy ? 1 : 0;
      lat = -1;
      if (done) lat = 0;
      else begin
         for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (busy) bcnt++;
            if (done) begin lat = i; break; end
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
      checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
      checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic check_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      int lat, bcnt, exp_lat;
      logic [63:0] e;
      e = ref_op(o, a, b);
      exp_lat = o[1] ? DIV_LAT : MUL_LAT;
      run_op(o, a, b, lat, bcnt);
      checks++; if (lat !== exp_lat) begin failures++; $display("FAIL %s_latency op=%0d a=%h b=%h got=%0d exp=%0d", name, o, a, b, lat, exp_lat); end
      checks++; if (bcnt !== exp_lat) begin failures++; $display("FAIL %s_busy_cycles op=%0d got=%0d exp=%0d", name, o, bcnt, exp_lat); end
      checks++; if (hi !== e[63:32]) begin failures++; $display("FAIL %s_hi op=%0d a=%h b=%h got=%h exp=%h", name, o, a, b, hi, e[63:32]); end
      checks++; if (lo !== e[31:0]) begin failures++; $display("FAIL %s_lo op=%0d a=%h b=%h got=%h exp=%h", name, o, a, b, lo, e[31:0]); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s_done_pulse got=%0b exp=0", name, done); end
   endtask

   task automatic test_mult;
      int lat, bcnt;
      run_op(3'd0, 32'hFFFF_FFFE, 32'd3, lat, bcnt);
      checks++; if (lat !== MUL_LAT) begin failures++; $display("FAIL mult_dir_lat got=%0d exp=%0d", lat, MUL_LAT); end
      checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_dir_hi got=%h exp=ffffffff", hi); end
      checks++; if (lo !== 32'hFFFF_FFFA) begin failures++; $display("FAIL mult_dir_lo got=%h exp=fffffffa", lo); end
      run_op(3'd1, 32'hFFFF_FFFE, 32'd3, lat, bcnt);
      checks++; if (hi !== 32'h0000_0002) begin failures++; $display("FAIL multu_dir_hi got=%h exp=00000002", hi); end
      checks++; if (lo !== 32'hFFFF_FFFA) begin failures++; $display("FAIL multu_dir_lo got=%h exp=fffffffa", lo); end
      for (int i = 0; i < 16; i++)
         check_op("mul_rand", 3'($urandom_range(0, 1)), $urandom, $urandom);
      check_op("mul_edge", 3'd0, 32'h8000_0000, 32'h8000_0000);
      check_op("mulu_edge", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
   endtask

   task automatic test_div;
      logic [31:0] b;
      check_op("div_neg7", 3'd2, 32'hFFFF_FFF9, 32'd2);
      checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_neg7_const got=%h:%h exp=ffffffff:fffffffd", hi, lo); end
      check_op("divu_7", 3'd3, 32'd7, 32'd2);
      checks++; if (lo !== 32'd3 || hi !== 32'd1) begin failures++; $display("FAIL divu_7_const got=%h:%h exp=00000001:00000003", hi, lo); end
      check_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      checks++; if (lo !== 32'h8000_0000 || hi !== 32'h0) begin failures++; $display("FAIL div_ovf_const got=%h:%h exp=00000000:80000000", hi, lo); end
      for (int i = 0; i < 16; i++) begin
         b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         if ($urandom_range(0, 1) == 1) b = -b;
         check_op("div_rand", 3'($urandom_range(2, 3)), $urandom, b);
      end
   endtask

   task automatic test_div_zero;
      check_op("divu_zero", 3'd3, 32'h0000_1234, 32'd0);
      checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'h0000_1234) begin failures++; $display("FAIL divu_zero_const got=%h:%h exp=00001234:ffffffff", hi, lo); end
      check_op("div_zero_neg", 3'd2, 32'hFFFF_FF00, 32'd0);
   endtask

   task automatic test_abort;
      logic [31:0] h0, l0;
      int done_seen;
      h0 = hi; l0 = lo;
      done_seen = 0;
      @(negedge clk);
      start = 1'b1; op = 3'd2; op1 = 32'd1000; op2 = 32'd7;
      @(posedge clk); #1;
      for (int i = 1; i < 20; i++) begin
         @(negedge clk);
         start = 1'b1; op = 3'(4 + (i % 2)); op1 = $urandom;
         @(posedge clk); #1;
         if (done) done_seen++;
      end
      @(negedge clk);
      start = 1'b0; op = 3'd6; abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", busy); end
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done || busy) done_seen++;
      end
      checks++; if (done_seen !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_seen); end
      checks++; if (hi !== h0) begin failures++; $display("FAIL abort_hi got=%h exp=%h", hi, h0); end
      checks++; if (lo !== l0) begin failures++; $display("FAIL abort_lo got=%h exp=%h", lo, l0); end
      @(negedge clk);
      start = 1'b1; op = 3'd4; op1 = ~h0; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0; op = 3'd6;
      checks++; if (hi !== h0 || done !== 1'b0) begin failures++; $display("FAIL abort_idle_start got hi=%h done=%0b exp hi=%h done=0", hi, done, h0); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] h0;
      @(negedge clk);
      start = 1'b1; op = 3'd4; op1 = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      h0 = hi;
      checks++; if (h0 !== 32'hDEAD_BEEF || done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mthi got hi=%h done=%0b busy=%0b exp hi=deadbeef done=1 busy=0", h0, done, busy); end
      @(negedge clk);
      op = 3'd5; op1 = 32'h0BAD_F00D;
      @(posedge clk); #1;
      checks++; if (lo !== 32'h0BAD_F00D || hi !== 32'hDEAD_BEEF || done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mtlo got hi=%h lo=%h done=%0b busy=%0b exp lo=0badf00d", hi, lo, done, busy); end
      @(negedge clk);
      start = 1'b1; op = 3'd7; op1 = 32'h1111_1111;
      @(posedge clk); #1;
      start = 1'b0; op = 3'd6;
      checks++; if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'hDEAD_BEEF || lo !== 32'h0BAD_F00D) begin failures++; $display("FAIL noop got done=%0b busy=%0b hi=%h lo=%h", done, busy, hi, lo); end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      start = 1'b1; op = 3'd2; op1 = 32'd12345; op2 = 32'd17;
      @(posedge clk); #1;
      start = 1'b0; op = 3'd6;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin failures++; $display("FAIL reset_mid got busy=%0b done=%0b hi=%h lo=%h exp all 0", busy, done, hi, lo); end
      @(negedge clk); rst_n = 1'b1;
      check_op("after_reset", 3'd3, 32'd100, 32'd9);
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end
endmodule
